sw_debounce_sync: RTL and testbench

- Conditions the ten raw slide-switch inputs before they reach the PIO switch input (pio_sw_external_connection_export) of the HPS/FPGA system.
- Per bit: a 2-flop synchronizer followed by a saturating debounce counter.
- Outputs a clean, stable switch vector and a one-cycle change pulse per bit.
- Runs on the fabric clock (50 MHz) that also drives clk_clk.

---
 rtl/sw_debounce_sync.sv | 120 ++++++++++++
 tb/tb_sw_debounce_sync.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce_sync.sv
// sw_debounce_sync
// Conditions raw slide-switch pins for the PIO switch input: each bit goes
// through a 2-flop synchronizer and a saturating debounce counter. The block
// produces a clean switch vector plus a one-cycle change pulse per bit.
//
// Handshake: none. sw_in is sampled every clk_clk rising edge. sw_out and
// sw_changed are registered. sw_changed[i] is high for exactly the one cycle
// in which sw_out[i] first shows its new value.
//
// Optional feature, macro SW_DEBOUNCE_EDGE_IRQ_EN:
//   defined     -> sticky edge_capture flags (write-1-to-clear through
//                  edge_clr, set wins over clear) and irq = OR of the flags.
//   not defined -> edge_capture and irq are tied to 0 and edge_clr is unused.
// The port list is identical in both builds.
module sw_debounce_sync #(
    parameter int WIDTH   = 10,
    parameter int CNT_MAX = 500000,
    parameter int CNT_W   = $clog2(CNT_MAX + 1)
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_changed,
    input  logic [WIDTH-1:0] edge_clr,
    output logic [WIDTH-1:0] edge_capture,
    output logic             irq
);

    // Last count value before the output flips. The counter therefore never
    // exceeds CNT_MAX-1 and cannot wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_sw_out;
    logic [WIDTH-1:0] r_sw_changed;
    logic [CNT_W-1:0] r_cnt [WIDTH];

    logic [WIDTH-1:0] w_differs;
    logic [WIDTH-1:0] w_done;

    // Per-bit decision: does the synchronized input disagree with the
    // output, and has it done so for long enough to be accepted?
    always_comb begin
        w_differs = r_s2 ^ r_sw_out;
        w_done    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_done[i] = w_differs[i] && (r_cnt[i] == CNT_LAST);
        end
    end

    // Two-flop synchronizer; only r_s2 is used downstream.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= sw_in;
            r_s2 <= r_s1;
        end
    end

    // Debounce counters: count consecutive disagreeing cycles, restart on any
    // agreement (glitch rejection) and after an accepted flip.
    always_ff @(posedge clk_clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (reset_reset || !w_differs[i] || w_done[i]) begin
                r_cnt[i] <= '0;
            end else begin
                r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
        end
    end

    // Debounced output and its one-cycle change pulse.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_sw_out     <= '0;
            r_sw_changed <= '0;
        end else begin
            r_sw_out     <= r_sw_out ^ w_done;
            r_sw_changed <= w_done;
        end
    end

    assign sw_out     = r_sw_out;
    assign sw_changed = r_sw_changed;

`ifdef SW_DEBOUNCE_EDGE_IRQ_EN
    logic [WIDTH-1:0] r_edge_capture;
    logic [WIDTH-1:0] w_edge_capture_next;
    logic             r_irq;

    // Sticky flags: a new change pulse wins over a clear in the same cycle.
    always_comb begin
        w_edge_capture_next = (r_edge_capture & ~edge_clr) | r_sw_changed;
    end

    // Registered capture flags and interrupt line, updated together.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_edge_capture <= '0;
            r_irq          <= 1'b0;
        end else begin
            r_edge_capture <= w_edge_capture_next;
            r_irq          <= |w_edge_capture_next;
        end
    end

    assign edge_capture = r_edge_capture;
    assign irq          = r_irq;
`else
    logic w_unused_edge_clr;
    assign w_unused_edge_clr = ^edge_clr;
    assign edge_capture      = '0;
    assign irq               = 1'b0;
`endif

endmodule

// File: tb/tb_sw_debounce_sync.sv
// tb_sw_debounce_sync
// Table-driven vectors for the debounce corner cases, a hand-written
// edge-capture/irq sequence, then randomized switch activity compared
// every cycle against a window-based reference model.
module tb_sw_debounce_sync;

    localparam int W       = 10;
    localparam int CNT_MAX = 4;
    localparam int HIST    = 8192;

`ifdef SW_DEBOUNCE_EDGE_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic         clk_clk;
    logic         reset_reset;
    logic [W-1:0] sw_in;
    logic [W-1:0] sw_out;
    logic [W-1:0] sw_changed;
    logic [W-1:0] edge_clr;
    logic [W-1:0] edge_capture;
    logic         irq;

    sw_debounce_sync #(
        .WIDTH   (W),
        .CNT_MAX (CNT_MAX)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset  (reset_reset),
        .sw_in        (sw_in),
        .sw_out       (sw_out),
        .sw_changed   (sw_changed),
        .edge_clr     (edge_clr),
        .edge_capture (edge_capture),
        .irq          (irq)
    );

    // ---------------- clock ----------------
    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    // ---------------- scoreboard counters ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model ----------------
    // Keeps the per-edge sample history. A bit flips at edge k when every
    // synchronized value over the last CNT_MAX edges (all later than the
    // bit's last flip or reset) disagreed with the current output.
    logic [W-1:0] samp_a [HIST];
    bit           rst_a  [HIST];
    int           last_ev [W];
    int           edge_k = 0;
    logic [W-1:0] m_out  = '0;
    logic [W-1:0] m_chg  = '0;
    logic [W-1:0] m_cap  = '0;
    logic         m_irq  = 1'b0;

    // Value the synchronizer presents before edge j (two edges of delay,
    // zero while the reset is still flushing through).
    function automatic logic [W-1:0] sync_at(int j);
        if (j < 2) return '0;
        if (rst_a[j-1] || rst_a[j-2]) return '0;
        return samp_a[j-2];
    endfunction

    function automatic void model_edge(bit rst, logic [W-1:0] sw, logic [W-1:0] clr);
        logic [W-1:0] flips;
        logic [W-1:0] nxt_cap;
        logic [W-1:0] sv;
        bit           all_diff;
        int           k;
        k = edge_k;
        samp_a[k] = rst ? '0 : sw;
        rst_a[k]  = rst;
        if (rst) begin
            m_out = '0;
            m_chg = '0;
            m_cap = '0;
            m_irq = 1'b0;
            for (int i = 0; i < W; i++) last_ev[i] = k;
        end else begin
            nxt_cap = IRQ_EN ? ((m_cap & ~clr) | m_chg) : '0;
            flips   = '0;
            for (int i = 0; i < W; i++) begin
                if (k - last_ev[i] >= CNT_MAX) begin
                    all_diff = 1'b1;
                    for (int j = k - CNT_MAX + 1; j <= k; j++) begin
                        sv = sync_at(j);
                        if (sv[i] == m_out[i]) all_diff = 1'b0;
                    end
                    if (all_diff) begin
                        flips[i]   = 1'b1;
                        last_ev[i] = k;
                    end
                end
            end
            m_out = m_out ^ flips;
            m_chg = flips;
            m_cap = nxt_cap;
            m_irq = |nxt_cap;
        end
        edge_k++;
    endfunction

    // ---------------- driver ----------------
    // Drive inputs, take one rising edge, advance the model, compare on the
    // following falling edge.
    task automatic step(input bit rst, input logic [W-1:0] sw, input logic [W-1:0] clr);
        reset_reset = rst;
        sw_in       = sw;
        edge_clr    = clr;
        @(posedge clk_clk);
        model_edge(rst, sw, clr);
        @(negedge clk_clk);
        check("model_sw_out", sw_out, m_out);
        check("model_sw_changed", sw_changed, m_chg);
        check("model_edge_capture", edge_capture, m_cap);
        check("model_irq", W'(irq), W'(m_irq));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit           rst;
        logic [W-1:0] sw;
        logic [W-1:0] out;
        logic [W-1:0] chg;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(int n, bit rst, logic [W-1:0] sw, logic [W-1:0] out, logic [W-1:0] chg);
        vec_t v;
        v.rst = rst;
        v.sw  = sw;
        v.out = out;
        v.chg = chg;
        for (int r = 0; r < n; r++) vecs.push_back(v);
    endfunction

    logic [W-1:0] exp_cap1;
    logic [W-1:0] sw_cur;
    logic [W-1:0] mask;
    bit           glitchy;
    bit           rnd_rst;

    initial begin
        reset_reset = 1'b1;
        sw_in       = '0;
        edge_clr    = '0;
        exp_cap1    = IRQ_EN ? W'(10'h001) : '0;

        // Reset with all switches high, then release: flip at edge 6.
        add(2, 1, 10'h3FF, 10'h000, 10'h000);
        add(5, 0, 10'h3FF, 10'h000, 10'h000);
        add(1, 0, 10'h3FF, 10'h3FF, 10'h3FF);
        add(1, 0, 10'h3FF, 10'h3FF, 10'h000);
        // Clean step on bit 0.
        add(1, 1, 10'h000, 10'h000, 10'h000);
        add(5, 0, 10'h001, 10'h000, 10'h000);
        add(1, 0, 10'h001, 10'h001, 10'h001);
        add(1, 0, 10'h001, 10'h001, 10'h000);
        // 3-cycle glitch on bit 3 is rejected.
        add(3, 0, 10'h009, 10'h001, 10'h000);
        add(5, 0, 10'h001, 10'h001, 10'h000);
        // 4-cycle pulse on bit 3 is accepted, then released.
        add(4, 0, 10'h009, 10'h001, 10'h000);
        add(1, 0, 10'h001, 10'h001, 10'h000);
        add(1, 0, 10'h001, 10'h009, 10'h008);
        add(3, 0, 10'h001, 10'h009, 10'h000);
        add(1, 0, 10'h001, 10'h001, 10'h008);
        add(1, 0, 10'h001, 10'h001, 10'h000);
        // Reset in the middle of a count on bit 9.
        add(1, 1, 10'h000, 10'h000, 10'h000);
        add(3, 0, 10'h200, 10'h000, 10'h000);
        add(1, 1, 10'h200, 10'h000, 10'h000);
        add(5, 0, 10'h200, 10'h000, 10'h000);
        add(1, 0, 10'h200, 10'h200, 10'h200);
        add(1, 0, 10'h200, 10'h200, 10'h000);
        // Several bits flipping together.
        add(1, 1, 10'h000, 10'h000, 10'h000);
        add(5, 0, 10'h155, 10'h000, 10'h000);
        add(1, 0, 10'h155, 10'h155, 10'h155);
        add(1, 0, 10'h155, 10'h155, 10'h000);

        for (int n = 0; n < vecs.size(); n++) begin
            step(vecs[n].rst, vecs[n].sw, '0);
            check($sformatf("vec%0d_sw_out", n), sw_out, vecs[n].out);
            check($sformatf("vec%0d_sw_changed", n), sw_changed, vecs[n].chg);
        end

        // Edge capture / irq sequence.
        step(1'b1, '0, '0);
        for (int n = 0; n < 6; n++) step(1'b0, W'(10'h001), '0);
        check("irqseq_rise_changed", sw_changed, W'(10'h001));
        step(1'b0, W'(10'h001), '0);
        check("irqseq_capture_set", edge_capture, exp_cap1);
        check("irqseq_irq_set", W'(irq), W'(IRQ_EN));
        step(1'b0, W'(10'h001), W'(10'h001));
        check("irqseq_capture_clr", edge_capture, '0);
        check("irqseq_irq_clr", W'(irq), '0);
        for (int n = 0; n < 6; n++) step(1'b0, '0, '0);
        check("irqseq_fall_out", sw_out, '0);
        check("irqseq_fall_changed", sw_changed, W'(10'h001));
        step(1'b0, '0, W'(10'h001));
        check("irqseq_set_wins", edge_capture, exp_cap1);
        check("irqseq_set_wins_irq", W'(irq), W'(IRQ_EN));
        step(1'b0, '0, W'(10'h001));
        check("irqseq_capture_clr2", edge_capture, '0);

        // Randomized activity: alternating glitchy and calm stretches.
        sw_cur = '0;
        for (int c = 0; c < 3000; c++) begin
            glitchy = ((c / 100) % 2) == 0;
            mask    = '0;
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, glitchy ? 1 : 15) == 0) mask[b] = 1'b1;
            end
            sw_cur  = sw_cur ^ mask;
            rnd_rst = ($urandom_range(0, 399) == 0);
            step(rnd_rst, sw_cur, W'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
